// File: rtl/reg32_write_arbiter_if.sv
// Bus between the requesters and the shared-register write arbiter.
// The master side is the requester pool; the slave side is the arbiter, which
// also drives the load enable and data of the shared register.
interface reg32_write_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 32
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        ack;
    logic                    reg_we;
    logic [DATA_W-1:0]       reg_din;
    logic                    busy;

    modport master (
        output req, wdata,
        input  gnt, ack, reg_we, reg_din, busy
    );

    modport slave (
        input  req, wdata,
        output gnt, ack, reg_we, reg_din, busy
    );
endinterface

// File: rtl/reg32_write_arbiter.sv
// Round-robin write arbiter for one shared load-enable register.
// A granted requester may write on consecutive cycles up to MAX_HOLD times;
// every release passes through IDLE for one cycle before re-arbitration.
module reg32_write_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  res,
    reg32_write_arbiter_if.slave  bus
);
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [HOLD_W-1:0]  hold_cnt;

    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   ack_q;
    logic               we_q;
    logic [DATA_W-1:0]  din_q;
    logic               busy_q;

    logic               sel_valid;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   next_ptr;
    logic               release_now;
    logic [DATA_W-1:0]  slice [N_REQ];

    // Unpack the flat write-data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            slice[i] = bus.wdata[i*DATA_W +: DATA_W];
        end
    end

    // Round-robin pick: first active request scanning ptr, ptr+1, ... wrapping.
    always_comb begin
        // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
        sel_valid = 1'b0;
        sel_idx   = ptr;
        for (int k = 0; k < N_REQ; k++) begin
            int               pos;
            logic [IDX_W-1:0] cand;
            pos = int'(ptr) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            cand = IDX_W'(pos);
            if (!sel_valid && bus.req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Release decision for the current owner and the pointer it leaves behind.
    always_comb begin
        next_ptr    = (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        release_now = !bus.req[owner] || (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    end

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (res) begin
            state    <= IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            gnt_q    <= '0;
            ack_q    <= '0;
            we_q     <= 1'b0;
            // NOTE: reg_din is a datapath register but still cleared, since its reset value is observable.
            din_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every branch sees the pre-edge state.
            we_q  <= 1'b0;
            ack_q <= '0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        state    <= OWN;
                        owner    <= sel_idx;
                        hold_cnt <= '0;
                        gnt_q    <= {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx;
                        busy_q   <= 1'b1;
                    end
                end
                OWN: begin
                    if (bus.req[owner]) begin
                        we_q     <= 1'b1;
                        din_q    <= slice[owner];
                        ack_q    <= gnt_q;
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                    if (release_now) begin
                        state  <= IDLE;
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                        ptr    <= next_ptr;
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.ack     = ack_q;
    assign bus.reg_we  = we_q;
    assign bus.reg_din = din_q;
    assign bus.busy    = busy_q;

    // Only one owner at a time, and an ack always accompanies a write.
    a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(gnt_q));
    a_ack_has_we  : assert property (@(posedge clk) (|ack_q) |-> we_q);
    a_busy_match  : assert property (@(posedge clk) busy_q == (|gnt_q));
endmodule

// File: tb/tb_reg32_write_arbiter.sv
// Directed bench for the shared-register write arbiter (N_REQ=4, MAX_HOLD=4).
module tb_reg32_write_arbiter;
    localparam int N_REQ    = 4;
    localparam int DATA_W   = 32;
    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic res = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg32_write_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    reg32_write_arbiter #(
        .N_REQ   (N_REQ),
        .DATA_W  (DATA_W),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    // Advance one rising edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observed outputs packed as {gnt, ack, reg_we, reg_din, busy}.
    function automatic logic [41:0] outs();
        return {bus.gnt, bus.ack, bus.reg_we, bus.reg_din, bus.busy};
    endfunction

    // Expected outputs in the same packing; busy follows the grant.
    function automatic logic [41:0] pk(input logic [3:0] g, input logic [3:0] a,
                                       input logic we, input logic [31:0] d);
        return {g, a, we, d, |g};
    endfunction

    task automatic do_reset();
        res       = 1'b1;
        bus.req   = '0;
        bus.wdata = '0;
        step();
        res = 1'b0;
    endtask

    task automatic test_reset();
        logic [41:0] e;
        res       = 1'b1;
        bus.req   = 4'b1111;
        bus.wdata = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        for (int c = 0; c < 2; c++) begin
            step();
            e = pk(4'b0000, 4'b0000, 1'b0, 32'h0);
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL reset_cycle%0d: got %h expected %h", c, outs(), e);
            end
        end
        res     = 1'b0;
        bus.req = '0;
        step();
        e = pk(4'b0000, 4'b0000, 1'b0, 32'h0);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", outs(), e);
        end
    endtask

    task automatic test_single_write();
        logic [41:0] e;
        do_reset();
        bus.req                = 4'b0100;
        bus.wdata[2*32 +: 32]  = 32'hDEADBEEF;
        step();
        e = pk(4'b0100, 4'b0000, 1'b0, 32'h0);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL single_grant: got %h expected %h", outs(), e);
        end
        step();
        e = pk(4'b0100, 4'b0100, 1'b1, 32'hDEADBEEF);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL single_write: got %h expected %h", outs(), e);
        end
        bus.req = 4'b0000;
        step();
        e = pk(4'b0000, 4'b0000, 1'b0, 32'hDEADBEEF);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL single_release: got %h expected %h", outs(), e);
        end
        // ptr is now 3, so requester 3 wins over requester 0.
        bus.req = 4'b1001;
        step();
        e = pk(4'b1000, 4'b0000, 1'b0, 32'hDEADBEEF);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL single_ptr3: got %h expected %h", outs(), e);
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_hold_limit();
        logic [41:0] e;
        do_reset();
        bus.req             = 4'b0001;
        bus.wdata[0 +: 32]  = 32'd1;
        step();
        e = pk(4'b0001, 4'b0000, 1'b0, 32'h0);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL hold_grant: got %h expected %h", outs(), e);
        end
        for (int n = 1; n <= 4; n++) begin
            bus.wdata[0 +: 32] = 32'(n);
            step();
            e = pk((n == 4) ? 4'b0000 : 4'b0001, 4'b0001, 1'b1, 32'(n));
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL hold_write%0d: got %h expected %h", n, outs(), e);
            end
        end
        bus.wdata[0 +: 32] = 32'd5;
        step();
        e = pk(4'b0001, 4'b0000, 1'b0, 32'd4);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL hold_regrant: got %h expected %h", outs(), e);
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_round_robin();
        int          order [5] = '{0, 1, 2, 3, 0};
        logic [31:0] last_din  = 32'h0;
        logic [31:0] d;
        logic [3:0]  oh;
        logic [41:0] e;
        do_reset();
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            oh = 4'b0001 << order[g];
            step();
            e = pk(oh, 4'b0000, 1'b0, last_din);
            checks++;
            if (outs() !== e) begin
                errors++;
                $display("FAIL rr_grant%0d: got %h expected %h", g, outs(), e);
            end
            if (g < 4) begin
                for (int w = 0; w < 4; w++) begin
                    d = 32'hA0000000 | 32'(order[g] << 8) | 32'(w);
                    bus.wdata[order[g]*32 +: 32] = d;
                    step();
                    e = pk((w == 3) ? 4'b0000 : oh, oh, 1'b1, d);
                    checks++;
                    if (outs() !== e) begin
                        errors++;
                        $display("FAIL rr_g%0d_w%0d: got %h expected %h", g, w, outs(), e);
                    end
                    last_din = d;
                end
            end
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_reset_mid_grant();
        logic [41:0] e;
        do_reset();
        // Early drop from requester 1 moves ptr to 2 before the interrupted grant.
        bus.req               = 4'b0010;
        bus.wdata[1*32 +: 32] = 32'hAAAA0001;
        step();
        step();
        e = pk(4'b0010, 4'b0010, 1'b1, 32'hAAAA0001);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL mid_first_write: got %h expected %h", outs(), e);
        end
        bus.req = 4'b0000;
        step();
        bus.req               = 4'b0100;
        bus.wdata[2*32 +: 32] = 32'hBBBB0002;
        step();
        e = pk(4'b0100, 4'b0000, 1'b0, 32'hAAAA0001);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL mid_grant2: got %h expected %h", outs(), e);
        end
        step();
        e = pk(4'b0100, 4'b0100, 1'b1, 32'hBBBB0002);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL mid_write1: got %h expected %h", outs(), e);
        end
        bus.wdata[2*32 +: 32] = 32'hCCCC0003;
        res = 1'b1;
        step();
        e = pk(4'b0000, 4'b0000, 1'b0, 32'h0);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL mid_reset: got %h expected %h", outs(), e);
        end
        res     = 1'b0;
        bus.req = 4'b1111;
        step();
        e = pk(4'b0001, 4'b0000, 1'b0, 32'h0);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL mid_ptr0: got %h expected %h", outs(), e);
        end
        bus.req = 4'b0000;
        step();
    endtask

    task automatic test_early_drop();
        logic [41:0] e;
        do_reset();
        bus.req               = 4'b1000;
        bus.wdata[3*32 +: 32] = 32'h12345678;
        step();
        e = pk(4'b1000, 4'b0000, 1'b0, 32'h0);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL drop_grant: got %h expected %h", outs(), e);
        end
        step();
        e = pk(4'b1000, 4'b1000, 1'b1, 32'h12345678);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL drop_write: got %h expected %h", outs(), e);
        end
        bus.req               = 4'b0000;
        bus.wdata[3*32 +: 32] = 32'h87654321;
        step();
        e = pk(4'b0000, 4'b0000, 1'b0, 32'h12345678);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL drop_release: got %h expected %h", outs(), e);
        end
        bus.req = 4'b1001;
        step();
        e = pk(4'b0001, 4'b0000, 1'b0, 32'h12345678);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL drop_scan0: got %h expected %h", outs(), e);
        end
        bus.req = 4'b0000;
        step();
    endtask

    initial begin
        bus.req   = '0;
        bus.wdata = '0;
        test_reset();
        test_single_write();
        test_hold_limit();
        test_round_robin();
        test_reset_mid_grant();
        test_early_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
